frog_controller: RTL and testbench

Owns the frog in the playfield: turns debounced switch presses into grid moves, detects arrival at the top row, counts lives on collision and signals game over. It is the producer side of the level-counter handshake: it drives `frog_at_top`, `lives` and `reset_level`, and obeys the `reset_frog` pulse returned by the level counter. Its position outputs feed the VGA frog sprite renderer.

---
 rtl/frog_controller.sv | 149 ++++++++++++++
 tb/tb_frog_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/frog_controller.sv
// Frog position, lives and game-state owner; switch edges and collisions act on the same clk edge they are sampled.
// Every output is a register. There is no backpressure: the frog waits on reset_frog while frog_at_top is held.
module frog_controller #(
  parameter int GRID_COLS  = 20,
  parameter int GRID_ROWS  = 15,
  parameter int START_COL  = 10,
  parameter int INIT_LIVES = 3,
  parameter int DEATH_HOLD = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       debounced_sw1,
  input  logic       debounced_sw2,
  input  logic       debounced_sw3,
  input  logic       debounced_sw4,
  input  logic       collision,
  input  logic       reset_frog,
  output logic [4:0] frog_col,
  output logic [3:0] frog_row,
  output logic       frog_at_top,
  output logic [1:0] lives,
  output logic       reset_level
);

  typedef enum logic [1:0] {PLAY, AT_TOP, DYING, GAME_OVER} state_t;

  localparam logic [4:0] SPAWN_COL = 5'(START_COL);
  localparam logic [3:0] SPAWN_ROW = 4'(GRID_ROWS - 1);
  localparam logic [4:0] MAX_COL   = 5'(GRID_COLS - 1);
  localparam logic [1:0] LIVES0    = 2'(INIT_LIVES);
  localparam int         CW        = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(DEATH_HOLD - 1);

  state_t        state, state_nx;
  logic [3:0]    sw, sw_prev, rise;
  logic          chord;
  logic [CW-1:0] death_cnt, cnt_nx;
  logic [4:0]    col_nx;
  logic [3:0]    row_nx;
  logic          top_nx, lvl_nx;
  logic [1:0]    lives_nx;

  assign sw    = {debounced_sw4, debounced_sw3, debounced_sw2, debounced_sw1};
  assign rise  = sw & ~sw_prev;
  assign chord = &sw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PLAY;
      sw_prev     <= 4'hF;  // a switch held through reset must not look like a press
      death_cnt   <= '0;
      frog_col    <= SPAWN_COL;
      frog_row    <= SPAWN_ROW;
      frog_at_top <= 1'b0;
      lives       <= LIVES0;
      reset_level <= 1'b0;
    end else begin
      state       <= state_nx;
      sw_prev     <= sw;
      death_cnt   <= cnt_nx;
      frog_col    <= col_nx;
      frog_row    <= row_nx;
      frog_at_top <= top_nx;
      lives       <= lives_nx;
      reset_level <= lvl_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = death_cnt;
    col_nx   = frog_col;
    row_nx   = frog_row;
    top_nx   = frog_at_top;
    lives_nx = lives;
    lvl_nx   = reset_level;
    if (chord) begin
      state_nx = PLAY;
      cnt_nx   = '0;
      col_nx   = SPAWN_COL;
      row_nx   = SPAWN_ROW;
      top_nx   = 1'b0;
      lives_nx = LIVES0;
      lvl_nx   = 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (collision) begin
            col_nx = SPAWN_COL;
            row_nx = SPAWN_ROW;
            cnt_nx = '0;
            if (lives <= 2'd1) begin
              lives_nx = 2'd0;
              lvl_nx   = 1'b1;
              state_nx = GAME_OVER;
            end else begin
              lives_nx = lives - 2'd1;
              state_nx = DYING;
            end
          end else if (reset_frog) begin
            col_nx = SPAWN_COL;
            row_nx = SPAWN_ROW;
          end else if (rise[0]) begin
            // Highest-priority press is the only candidate; a clamped move is simply dropped.
            if (frog_row != 4'd0) begin
              row_nx = frog_row - 4'd1;
              if (frog_row == 4'd1) begin
                top_nx   = 1'b1;
                state_nx = AT_TOP;
              end
            end
          end else if (rise[1]) begin
            if (frog_row != SPAWN_ROW) row_nx = frog_row + 4'd1;
          end else if (rise[2]) begin
            if (frog_col != 5'd0) col_nx = frog_col - 5'd1;
          end else if (rise[3]) begin
            if (frog_col != MAX_COL) col_nx = frog_col + 5'd1;
          end
        end
        AT_TOP: begin
          if (reset_frog) begin
            col_nx   = SPAWN_COL;
            row_nx   = SPAWN_ROW;
            top_nx   = 1'b0;
            state_nx = PLAY;
          end
        end
        DYING: begin
          col_nx = SPAWN_COL;
          row_nx = SPAWN_ROW;
          if (death_cnt == HOLD_LAST) begin
            cnt_nx   = '0;
            state_nx = PLAY;
          end else begin
            cnt_nx = death_cnt + CW'(1);
          end
        end
        GAME_OVER: begin
          col_nx   = SPAWN_COL;
          row_nx   = SPAWN_ROW;
          lives_nx = 2'd0;
          lvl_nx   = 1'b1;
        end
        default: state_nx = PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_frog_controller.sv
// Scoreboard bench for frog_controller: a rule-level game model predicts outputs, a monitor compares each cycle.
module tb_frog_controller;

  localparam int GRID_COLS  = 20;
  localparam int GRID_ROWS  = 15;
  localparam int START_COL  = 10;
  localparam int INIT_LIVES = 3;
  localparam int DEATH_HOLD = 4;

  localparam int MD_PLAY = 0, MD_TOP = 1, MD_DYING = 2, MD_OVER = 3;

  typedef struct packed {
    logic [4:0] col;
    logic [3:0] row;
    logic       top;
    logic [1:0] lives;
    logic       lvl;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic debounced_sw1 = 1'b0, debounced_sw2 = 1'b0, debounced_sw3 = 1'b0, debounced_sw4 = 1'b0;
  logic collision = 1'b0, reset_frog = 1'b0;
  logic [4:0] frog_col;
  logic [3:0] frog_row;
  logic       frog_at_top;
  logic [1:0] lives;
  logic       reset_level;

  int tests = 0;
  int errors = 0;

  obs_t exp_q[$];

  int m_col, m_row, m_top, m_lives, m_mode, m_hold;
  logic [3:0] m_prev;

  frog_controller #(
    .GRID_COLS(GRID_COLS), .GRID_ROWS(GRID_ROWS), .START_COL(START_COL),
    .INIT_LIVES(INIT_LIVES), .DEATH_HOLD(DEATH_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .debounced_sw1(debounced_sw1), .debounced_sw2(debounced_sw2),
    .debounced_sw3(debounced_sw3), .debounced_sw4(debounced_sw4),
    .collision(collision), .reset_frog(reset_frog),
    .frog_col(frog_col), .frog_row(frog_row), .frog_at_top(frog_at_top),
    .lives(lives), .reset_level(reset_level)
  );

  always #5 clk = ~clk;

  function automatic obs_t dut_obs();
    return {frog_col, frog_row, frog_at_top, lives, reset_level};
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.col   = 5'(m_col);
    o.row   = 4'(m_row);
    o.top   = (m_top != 0);
    o.lives = 2'(m_lives);
    o.lvl   = (m_mode == MD_OVER);
    return o;
  endfunction

  function automatic int dcol(int i);
    case (i) 2: return -1; 3: return 1; default: return 0; endcase
  endfunction

  function automatic int drow(int i);
    case (i) 0: return -1; 1: return 1; default: return 0; endcase
  endfunction

  task automatic spawn();
    m_col = START_COL;
    m_row = GRID_ROWS - 1;
  endtask

  task automatic model_reset();
    spawn();
    m_top = 0; m_lives = INIT_LIVES; m_mode = MD_PLAY; m_hold = 0; m_prev = 4'hF;
  endtask

  // One clock edge of the game rules, switch bit 0 = up .. bit 3 = right.
  task automatic model_edge(input logic [3:0] s, input bit c, input bit rf);
    logic [3:0] rise;
    int pick, nc, nr;
    rise = s & ~m_prev;
    m_prev = s;
    if (s == 4'b1111) begin
      spawn();
      m_top = 0; m_lives = INIT_LIVES; m_mode = MD_PLAY; m_hold = 0;
      return;
    end
    case (m_mode)
      MD_PLAY: begin
        if (c) begin
          m_lives = m_lives - 1;
          spawn();
          if (m_lives == 0) m_mode = MD_OVER;
          else begin m_mode = MD_DYING; m_hold = DEATH_HOLD; end
        end else if (rf) begin
          spawn();
        end else begin
          pick = -1;
          for (int i = 3; i >= 0; i--) if (rise[i]) pick = i;
          if (pick >= 0) begin
            nc = m_col + dcol(pick);
            nr = m_row + drow(pick);
            if (nc >= 0 && nc < GRID_COLS && nr >= 0 && nr < GRID_ROWS) begin
              m_col = nc; m_row = nr;
              if (nr == 0) begin m_top = 1; m_mode = MD_TOP; end
            end
          end
        end
      end
      MD_TOP: if (rf) begin spawn(); m_top = 0; m_mode = MD_PLAY; end
      MD_DYING: begin
        m_hold = m_hold - 1;
        if (m_hold == 0) m_mode = MD_PLAY;
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic [3:0] s, input bit c, input bit rf);
    {debounced_sw4, debounced_sw3, debounced_sw2, debounced_sw1} = s;
    collision = c;
    reset_frog = rf;
    @(posedge clk);
    model_edge(s, c, rf);
    exp_q.push_back(model_obs());
    #2;
  endtask

  task automatic check_reset_values(input string name);
    obs_t e, a;
    e = '{col: 5'(START_COL), row: 4'(GRID_ROWS - 1), top: 1'b0, lives: 2'(INIT_LIVES), lvl: 1'b0};
    a = dut_obs();
    tests++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got col=%0d row=%0d top=%0d lives=%0d lvl=%0d, want col=%0d row=%0d top=%0d lives=%0d lvl=%0d",
               name, a.col, a.row, a.top, a.lives, a.lvl, e.col, e.row, e.top, e.lives, e.lvl);
    end
  endtask

  // Monitor: one registered output word per cycle, compared away from the active edge.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_obs();
        tests++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_outputs @%0t: got col=%0d row=%0d top=%0d lives=%0d lvl=%0d, want col=%0d row=%0d top=%0d lives=%0d lvl=%0d",
                   $time, a.col, a.row, a.top, a.lives, a.lvl, e.col, e.row, e.top, e.lives, e.lvl);
        end
      end
    end
  end

  initial begin
    logic [3:0] s;
    bit c, rf;
    debounced_sw1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_values("reset_state");
    #1 rst_n = 1'b1;
    model_reset();

    // Held switch through reset, then 14 presses to the top, then presses while frozen.
    step(4'b0001, 0, 0); step(4'b0001, 0, 0);
    for (int i = 0; i < 14; i++) begin step(4'b0001, 0, 0); step(4'b0000, 0, 0); end
    step(4'b0001, 0, 0); step(4'b0000, 0, 0); step(4'b1000, 0, 0); step(4'b0000, 0, 0);

    // Handshake: two reset_frog cycles with a press in the second, then a press after.
    step(4'b0000, 0, 1); step(4'b0001, 0, 1);
    step(4'b0000, 0, 0); step(4'b0001, 0, 0); step(4'b0000, 0, 0);

    // Left edge clamp, then up and right on the same edge.
    for (int i = 0; i < 12; i++) begin step(4'b0100, 0, 0); step(4'b0000, 0, 0); end
    step(4'b1001, 0, 0); step(4'b0000, 0, 0);

    // Collision beats an up edge; presses every cycle through the hold.
    step(4'b0001, 1, 0);
    for (int k = 0; k < 7; k++) step((k % 2 == 0) ? 4'b0100 : 4'b0001, 0, 0);
    step(4'b0000, 0, 0);

    // Restart, then three collisions to game over, extra collisions, restart again.
    step(4'b1111, 0, 0); step(4'b0000, 0, 0);
    for (int n = 0; n < 3; n++) begin
      step(4'b0000, 1, 0);
      repeat (DEATH_HOLD + 1) step(4'b0000, 0, 0);
    end
    step(4'b0000, 1, 0); step(4'b0001, 1, 1); step(4'b0000, 0, 0);
    step(4'b1111, 1, 0); step(4'b0000, 0, 0); step(4'b0001, 0, 0); step(4'b0000, 0, 0);

    // Asynchronous reset in the middle of the death hold.
    step(4'b0000, 1, 0); step(4'b0000, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values("async_reset_mid_dying");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Random play with a loosely behaved level counter.
    for (int i = 0; i < 3000; i++) begin
      s  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      c  = ($urandom_range(0, 29) == 0);
      rf = ($urandom_range(0, 19) == 0) || (frog_at_top && ($urandom_range(0, 1) == 1));
      step(s, c, rf);
    end

    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
